// File: rtl/sha256_compress_core.sv
// Purpose: iterative SHA-256 compression, one round per clock, miner datapath.
// Latency: start edge N -> done pulse after edge N+ROUNDS+1 (65 cycles at 64 rounds).
// Backpressure: none; start is ignored while busy, accepted again in the done cycle.

// Plain 32-bit inverter, kept as its own cell so Ch has a dedicated ~e path.
module sha256_not32 (
    input  logic [31:0] a,
    output logic [31:0] y
);
    assign y = ~a;
endmodule

module sha256_compress_core #(
    parameter int ROUNDS = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] state_in,
    input  logic [511:0] block_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t      state;
    logic [5:0]  rnd;
    logic [31:0] hin [8];
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] w [16];

    logic [31:0] not_e;
    logic [31:0] ch;
    logic [31:0] maj;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] w_new;

    sha256_not32 u_not_e (
        .a (e),
        .y (not_e)
    );

    assign ch  = (e & f) ^ (not_e & g);
    assign maj = (a & b) ^ (a & c) ^ (b & c);
    assign t1  = h + big_sigma1(e) + ch + K[rnd] + w[0];
    assign t2  = big_sigma0(a) + maj;
    // w[i] holds W[t+i] during round t, so the appended word is W[t+16].
    assign w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            digest <= '0;
            rnd    <= '0;
            a <= '0; b <= '0; c <= '0; d <= '0;
            e <= '0; f <= '0; g <= '0; h <= '0;
            for (int i = 0; i < 8; i++) hin[i] <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 8; i++) hin[i] <= state_in[255 - 32*i -: 32];
                        for (int i = 0; i < 16; i++) w[i] <= block_in[511 - 32*i -: 32];
                        a <= state_in[255:224];
                        b <= state_in[223:192];
                        c <= state_in[191:160];
                        d <= state_in[159:128];
                        e <= state_in[127:96];
                        f <= state_in[95:64];
                        g <= state_in[63:32];
                        h <= state_in[31:0];
                        rnd   <= '0;
                        busy  <= 1'b1;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    h <= g;
                    g <= f;
                    f <= e;
                    e <= d + t1;
                    d <= c;
                    c <= b;
                    b <= a;
                    a <= t1 + t2;
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_new;
                    rnd <= rnd + 6'd1;
                    if (rnd == LAST_RND) state <= FINAL;
                end
                FINAL: begin
                    digest <= {hin[0] + a, hin[1] + b, hin[2] + c, hin[3] + d,
                               hin[4] + e, hin[5] + f, hin[6] + g, hin[7] + h};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
